// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer and its 7-segment display path.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Segment codes, active-high, bit7 = dp, bits 6..0 = gfedcba
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h27;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h67;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to 7-segment code; non-decimal nibbles show a dash.
module seg7_encode
  import countdown_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/countdown_display.sv
// N-digit BCD countdown timer with load/start/pause control, expiry flash and a
// time-multiplexed 7-segment scanner with optional leading-zero blanking.
module countdown_display
  import countdown_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned BLANK_LZ   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS + 1);

  state_e                state_q, state_d;
  logic [VAL_W-1:0]      value_q, value_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  flash_q, flash_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

  logic [VAL_W-1:0] clamp_c;
  logic [VAL_W-1:0] dec_c;
  logic             dec_borrow_c;
  logic             wrap_c;
  logic             scan_wrap_c;
  logic [3:0]       nib_c;
  logic             blank_c;
  logic             zero_above_c;
  logic [7:0]       seg_enc_c;

  // Nibble-wise clamp of the load value and BCD decrement with borrow
  always_comb begin
    clamp_c      = '0;
    dec_c        = '0;
    dec_borrow_c = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      clamp_c[4*i +: 4] = (load_val[4*i +: 4] > BCD_MAX) ? BCD_MAX : load_val[4*i +: 4];
      if (!dec_borrow_c) begin
        dec_c[4*i +: 4] = value_q[4*i +: 4];
      end else if (value_q[4*i +: 4] == 4'd0) begin
        dec_c[4*i +: 4] = BCD_MAX;
      end else begin
        dec_c[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
        dec_borrow_c    = 1'b0;
      end
    end
  end

  // Control FSM and step prescaler
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    presc_d = presc_q;
    flash_d = flash_q;
    done_d  = 1'b0;
    wrap_c  = (presc_q == PRESC_W'(TICK_DIV - 1));

    if (load) begin
      state_d = ST_IDLE;
      value_d = clamp_c;
      presc_d = '0;
      flash_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            presc_d = '0;
            if (value_q == '0) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        // Leaving PAUSED counts in the same cycle so a pause costs exactly its length
        ST_RUN, ST_PAUSED: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RUN;
            if (wrap_c) begin
              presc_d = '0;
              value_d = dec_c;
              if (dec_c == '0) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
              end
            end else begin
              presc_d = presc_q + PRESC_W'(1);
            end
          end
        end
        ST_EXPIRED: begin
          if (wrap_c) begin
            presc_d = '0;
            flash_d = ~flash_q;
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
  end

  // Digit scanner, digit select and leading-zero detection
  always_comb begin
    scan_wrap_c = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d  = scan_wrap_c ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d       = idx_q;
    if (scan_wrap_c) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    nib_c        = 4'd0;
    blank_c      = 1'b0;
    zero_above_c = 1'b1;
    digit_en_d   = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above_c = zero_above_c && (value_q[4*i +: 4] == 4'd0);
      digit_en_d[i] = (idx_q == IDX_W'(i));
      if (idx_q == IDX_W'(i)) begin
        nib_c   = value_q[4*i +: 4];
        blank_c = (BLANK_LZ != 0) && (i != 0) && zero_above_c;
      end
    end

    seg_d = (blank_c || flash_q) ? SEG_BLANK : seg_enc_c;
  end

  seg7_encode u_seg7_encode (
    .bcd   (nib_c),
    .seg_c (seg_enc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      presc_q    <= '0;
      flash_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      digit_en_q <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      presc_q    <= presc_d;
      flash_q    <= flash_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign value    = value_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign seg_out  = seg_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_countdown_display.sv
// Scoreboard bench for countdown_display: a decimal-arithmetic reference model queues
// expected outputs every cycle; a monitor pops and compares on the falling edge.
module tb_countdown_display;

  localparam int unsigned ND = 2;
  localparam int unsigned TD = 4;
  localparam int unsigned SD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] value_o, value_lz;
  logic       busy_o, busy_lz, done_o, done_lz;
  logic [7:0] seg_o, seg_lz;
  logic [1:0] den_o, den_lz;

  int n_tests = 0;
  int n_fail  = 0;

  countdown_display #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .value(value_o), .busy(busy_o), .done(done_o), .seg_out(seg_o), .digit_en(den_o)
  );

  countdown_display #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .value(value_lz), .busy(busy_lz), .done(done_lz), .seg_out(seg_lz), .digit_en(den_lz)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic [7:0] seg;
    logic [7:0] seg_lz;
    logic [1:0] den;
  } exp_t;

  exp_t exp_q[$];

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mstate_e;
  mstate_e m_state = M_IDLE;
  int  m_val = 0, m_presc = 0, m_scan = 0, m_idx = 0;
  bit  m_flash = 1'b0, m_done = 1'b0;
  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h27, 8'h7F, 8'h67};

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic int digit_of(input int v, input int i);
    return (v / pow10(i)) % 10;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < int'(ND); i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic int clamp_val(input logic [7:0] lv);
    int r = 0;
    int d;
    for (int i = 0; i < int'(ND); i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * pow10(i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: countdown as a plain integer, display derived from decimal digits
  initial forever begin
    exp_t e;
    int   d;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = M_IDLE; m_val = 0; m_presc = 0; m_scan = 0; m_idx = 0;
      m_flash = 1'b0; m_done = 1'b0;
      exp_q.delete();
    end else begin
      d        = digit_of(m_val, m_idx);
      e.den    = 2'(1 << m_idx);
      e.seg    = m_flash ? 8'h00 : seg_tab[d];
      e.seg_lz = (m_flash || (m_idx > 0 && m_val < pow10(m_idx))) ? 8'h00 : seg_tab[d];
      m_done   = 1'b0;

      if (load) begin
        m_val = clamp_val(load_val); m_presc = 0; m_state = M_IDLE; m_flash = 1'b0;
      end else begin
        case (m_state)
          M_IDLE: if (start) begin
            m_presc = 0;
            if (m_val == 0) begin m_state = M_EXPIRED; m_done = 1'b1; end
            else m_state = M_RUN;
          end
          M_RUN, M_PAUSED: if (pause) m_state = M_PAUSED;
          else begin
            m_state = M_RUN;
            if (m_presc == int'(TD) - 1) begin
              m_presc = 0;
              m_val   = m_val - 1;
              if (m_val == 0) begin m_state = M_EXPIRED; m_done = 1'b1; end
            end else m_presc++;
          end
          M_EXPIRED: if (m_presc == int'(TD) - 1) begin
            m_presc = 0; m_flash = !m_flash;
          end else m_presc++;
          default: m_state = M_IDLE;
        endcase
      end

      if (m_scan == int'(SD) - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % int'(ND);
      end else m_scan++;

      e.value = to_bcd(m_val);
      e.busy  = (m_state == M_RUN) || (m_state == M_PAUSED);
      e.done  = m_done;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expectation per rising edge, compared on the following falling edge
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("value",     value_o,  e.value);
      chk("busy",      busy_o,   e.busy);
      chk("done",      done_o,   e.done);
      chk("digit_en",  den_o,    e.den);
      chk("seg_out",   seg_o,    e.seg);
      chk("lz_value",  value_lz, e.value);
      chk("lz_busy",   busy_lz,  e.busy);
      chk("lz_done",   done_lz,  e.done);
      chk("lz_digit",  den_lz,   e.den);
      chk("lz_seg",    seg_lz,   e.seg_lz);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_value"}, {value_o, value_lz}, 16'h0);
    chk({tag, "_busy"},  {busy_o, busy_lz},   2'b00);
    chk({tag, "_done"},  {done_o, done_lz},   2'b00);
    chk({tag, "_seg"},   {seg_o, seg_lz},     16'h0);
    chk({tag, "_den"},   {den_o, den_lz},     4'h0);
  endtask

  initial begin
    int n;
    int done_cnt;
    bit seen_hi, seen_lo;

    // Reset and first cycle after release
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rel_den", den_o, 2'b01);
    chk("rel_seg", seg_o, 8'h3F);
    chk("rel_value", value_o, 8'h00);
    chk("rel_busy", busy_o, 1'b0);

    // Full countdown from 12 with a single done pulse
    pulse_load(8'h12);
    pulse_start();
    chk("a_busy", busy_o, 1'b1);
    done_cnt = 0;
    repeat (12 * TD + 20) begin
      if (done_o) done_cnt++;
      tick();
    end
    chk("a_done_once", done_cnt, 1);
    chk("a_value_zero", value_o, 8'h00);

    // Pause for 10 cycles: run time grows from 40 to 50 edges
    pulse_load(8'h10);
    pulse_start();
    n = 1;
    while (!done_o && n < 300) begin
      pause = (n >= 15 && n < 25);
      tick();
      n++;
    end
    pause = 1'b0;
    chk("b_run_edges", n - 1, 50);
    chk("b_done", done_o, 1'b1);

    // Load wins over simultaneous start; start at zero expires at once
    load = 1'b1; start = 1'b1; load_val = 8'h05;
    tick();
    load = 1'b0; start = 1'b0;
    chk("c_value", value_o, 8'h05);
    chk("c_busy", busy_o, 1'b0);
    tick();
    chk("c_still_idle", busy_o, 1'b0);
    pulse_load(8'h00);
    pulse_start();
    chk("c_zero_done", done_o, 1'b1);
    chk("c_zero_busy", busy_o, 1'b0);
    tick();
    chk("c_done_pulse", done_o, 1'b0);

    // Clamping and leading-zero blanking
    pulse_load(8'hAF);
    chk("d_clamp", value_o, 8'h99);
    pulse_load(8'h07);
    seen_hi = 1'b0; seen_lo = 1'b0;
    repeat (8) begin
      tick();
      if (den_lz == 2'b10) begin chk("d_lz_hi", seg_lz, 8'h00); seen_hi = 1'b1; end
      if (den_lz == 2'b01) begin chk("d_lz_lo", seg_lz, 8'h27); seen_lo = 1'b1; end
    end
    chk("d_scan_seen", {seen_hi, seen_lo}, 2'b11);

    // Asynchronous reset mid-run
    pulse_load(8'h09);
    pulse_start();
    n = 0;
    while (value_o != 8'h06 && n < 100) begin tick(); n++; end
    chk("e_reach_06", value_o, 8'h06);
    rst_n = 1'b0;
    #1 check_reset("e_rst");
    tick();
    chk("e_no_done", {done_o, done_lz}, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: pulse_load(8'($urandom_range(0, 255)));
        3, 4:    pulse_start();
        5: begin
          pause = 1'b1;
          repeat ($urandom_range(1, 8)) tick();
          pause = 1'b0;
        end
        6: begin
          load = 1'b1; start = 1'b1; load_val = 8'($urandom_range(0, 255));
          tick();
          load = 1'b0; start = 1'b0;
        end
        7: if ($urandom_range(0, 3) == 0) begin
          rst_n = 1'b0;
          #1 check_reset("rnd_rst");
          tick();
          rst_n = 1'b1;
        end else tick();
        8: begin
          pulse_load({4'h0, 4'($urandom_range(0, 3))});
          pulse_start();
          repeat (20) tick();
        end
        default: repeat ($urandom_range(1, 30)) tick();
      endcase
    end

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
